// File: rtl/writeback_stage_if.sv
// MEM/WB pipeline interface.
// The memory stage drives it (master); the writeback stage consumes it (slave).
// There is no back-pressure: every beat presented with MEMWB_ready=1 is taken.
interface writeback_stage_if #(
    parameter int XLEN = 64
);
    logic            MEMWB_ready;
    logic [XLEN-1:0] memwb_aluresult;
    logic [XLEN-1:0] memwb_loadeddata;
    logic [5:0]      memwb_rd;
    logic            memwb_load;
    logic [2:0]      memwb_funct3;

    modport master (
        output MEMWB_ready,
        output memwb_aluresult,
        output memwb_loadeddata,
        output memwb_rd,
        output memwb_load,
        output memwb_funct3
    );

    modport slave (
        input MEMWB_ready,
        input memwb_aluresult,
        input memwb_loadeddata,
        input memwb_rd,
        input memwb_load,
        input memwb_funct3
    );
endinterface

// File: rtl/writeback_stage.sv
// Writeback stage: registers one MEM/WB beat, picks the ALU result or the extracted
// load value, writes the integer register file one edge later, and serves the two
// decode read ports with a bypass from the beat currently in WB.
// Misaligned loads and funct3=111 loads raise a one-cycle flag and suppress the write.
module writeback_stage #(
    parameter int XLEN     = 64,
    parameter int NREGS    = 32,
    parameter int RETIRE_W = 64
) (
    input  logic                clk,
    input  logic                reset,
    writeback_stage_if.slave    memwb,
    input  logic [4:0]          rs1_addr,
    input  logic [4:0]          rs2_addr,
    output logic [XLEN-1:0]     rs1_data,
    output logic [XLEN-1:0]     rs2_data,
    output logic                wb_valid,
    output logic [4:0]          wb_rd,
    output logic [XLEN-1:0]     wb_data,
    output logic                wb_misaligned,
    output logic                wb_illegal,
    output logic [RETIRE_W-1:0] retired
);

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_BAD = 3'b111;

    logic                r_valid;
    logic [XLEN-1:0]     r_alu;
    logic [XLEN-1:0]     r_ldata;
    logic [5:0]          r_rd;
    logic                r_load;
    logic [2:0]          r_funct3;
    logic [RETIRE_W-1:0] r_retired;
    logic [XLEN-1:0]     r_regs [NREGS];

    logic [2:0]      w_off;
    logic [XLEN-1:0] w_lane;
    logic [XLEN-1:0] w_load_val;
    logic            w_mis_raw;
    logic            w_ill_raw;
    logic [XLEN-1:0] w_data;
    logic            w_we;

    // Capture the MEM/WB payload; the payload holds on idle cycles, only valid drops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid  <= 1'b0;
            r_alu    <= '0;
            r_ldata  <= '0;
            r_rd     <= '0;
            r_load   <= 1'b0;
            r_funct3 <= '0;
        end else if (memwb.MEMWB_ready) begin
            r_valid  <= 1'b1;
            r_alu    <= memwb.memwb_aluresult;
            r_ldata  <= memwb.memwb_loadeddata;
            r_rd     <= memwb.memwb_rd;
            r_load   <= memwb.memwb_load;
            r_funct3 <= memwb.memwb_funct3;
        end else begin
            r_valid  <= 1'b0;
        end
    end

    // Shift the addressed byte lane down to bit 0 of the doubleword.
    always_comb begin
        w_off  = r_alu[2:0];
        w_lane = r_ldata >> {w_off, 3'b000};
    end

    // Size/sign extension of the load lane.
    always_comb begin
        w_load_val = '0;
        case (r_funct3)
            F3_LB:   w_load_val = {{(XLEN-8){w_lane[7]}},   w_lane[7:0]};
            F3_LH:   w_load_val = {{(XLEN-16){w_lane[15]}}, w_lane[15:0]};
            F3_LW:   w_load_val = {{(XLEN-32){w_lane[31]}}, w_lane[31:0]};
            F3_LD:   w_load_val = w_lane;
            F3_LBU:  w_load_val = {{(XLEN-8){1'b0}},        w_lane[7:0]};
            F3_LHU:  w_load_val = {{(XLEN-16){1'b0}},       w_lane[15:0]};
            F3_LWU:  w_load_val = {{(XLEN-32){1'b0}},       w_lane[31:0]};
            default: w_load_val = '0;
        endcase
    end

    // Alignment check by access size; funct3=111 has size bits 11 but is not a doubleword.
    always_comb begin
        w_mis_raw = 1'b0;
        w_ill_raw = 1'b0;
        if (r_load) begin
            case (r_funct3[1:0])
                2'b01:   w_mis_raw = w_off[0];
                2'b10:   w_mis_raw = |w_off[1:0];
                2'b11:   w_mis_raw = (r_funct3 == F3_LD) && (|w_off);
                default: w_mis_raw = 1'b0;
            endcase
            w_ill_raw = (r_funct3 == F3_BAD);
        end
    end

    // Result select; faulting loads produce zero so nothing stale leaks onto wb_data.
    always_comb begin
        w_data = r_alu;
        if (r_load) begin
            if (w_mis_raw || w_ill_raw) begin
                w_data = '0;
            end else begin
                w_data = w_load_val;
            end
        end
    end

    // Write qualifier; also used as the bypass hit condition so both always agree.
    always_comb begin
        w_we = r_valid && !r_rd[5] && (r_rd[4:0] != 5'd0) && !w_mis_raw && !w_ill_raw;
    end

    // Register file write; x0 is never written and so reads as zero from storage too.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we) begin
            r_regs[r_rd[4:0]] <= w_data;
        end
    end

    // Retired count: every beat leaving WB counts, suppressed or not; wraps naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_retired <= '0;
        end else if (r_valid) begin
            r_retired <= r_retired + RETIRE_W'(1);
        end
    end

    // Read port 1 with bypass from the beat in WB.
    always_comb begin
        rs1_data = r_regs[rs1_addr];
        if (rs1_addr == 5'd0) begin
            rs1_data = '0;
        end else if (w_we && (rs1_addr == r_rd[4:0])) begin
            rs1_data = w_data;
        end
    end

    // Read port 2 with bypass from the beat in WB.
    always_comb begin
        rs2_data = r_regs[rs2_addr];
        if (rs2_addr == 5'd0) begin
            rs2_data = '0;
        end else if (w_we && (rs2_addr == r_rd[4:0])) begin
            rs2_data = w_data;
        end
    end

    // Observation outputs; flags only pulse while a beat is actually in WB.
    always_comb begin
        wb_valid      = r_valid;
        wb_rd         = r_rd[4:0];
        wb_data       = w_data;
        wb_misaligned = r_valid && w_mis_raw;
        wb_illegal    = r_valid && w_ill_raw;
        retired       = r_retired;
    end

endmodule
